divider_seq: RTL

Sequential restoring divider, the inverse counterpart of the combinational multiplier in the datapath helper set. It accepts an unsigned (optionally signed) dividend/divisor pair through a start/done handshake and produces quotient and remainder after WIDTH iterations, one quotient bit per clock. It sits beside the multiplier in the execute stage and serves divide/remainder instructions that tolerate multi-cycle latency.

---
 rtl/divider_seq_pkg.sv | 20 ++
 rtl/divider_seq_div_step.sv | 30 +++
 rtl/divider_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and iteration-counter sizing.
package divider_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    localparam int unsigned DivWidthDefault = 32;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int unsigned div_cnt_width(int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned DivCntWidthDefault = div_cnt_width(DivWidthDefault);

endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, try to
// subtract the divisor and keep the difference when it does not underflow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_i};

    // Non-negative trial means the divisor fits: restore is skipped, bit is 1.
    always_comb begin
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider: start/done handshake, one quotient bit per
// clock, WIDTH iterations. Divide-by-zero completes in one cycle with dbz set.
// Optional signed support is compiled in with the DIV_SIGNED_EN macro.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidthDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CntW = div_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] res_quo, res_rem;
    logic             accept_run;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    assign accept_run = start_i && (state_q != StRun) && (divisor_i != '0);

`ifdef DIV_SIGNED_EN
    logic neg_dvd, neg_dvs;
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    // Magnitudes feed the unsigned core; sign flags are captured at accept.
    always_comb begin
        neg_dvd   = signed_op_i & dividend_i[WIDTH-1];
        neg_dvs   = signed_op_i & divisor_i[WIDTH-1];
        dvd_mag   = neg_dvd ? -dividend_i : dividend_i;
        dvs_mag   = neg_dvs ? -divisor_i : divisor_i;
        neg_quo_d = accept_run ? (neg_dvd ^ neg_dvs) : neg_quo_q;
        neg_rem_d = accept_run ? neg_dvd : neg_rem_q;
        res_quo   = neg_quo_q ? -step_quo : step_quo;
        res_rem   = neg_rem_q ? -step_rem : step_rem;
    end

    // Sign flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op_i;
    assign dvd_mag          = dividend_i;
    assign dvs_mag          = divisor_i;
    assign res_quo          = step_quo;
    assign res_rem          = step_rem;
`endif

    // Next-state logic: accept in IDLE/DONE, iterate in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    if (divisor_i == '0) begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = StRun;
                        cnt_d   = CntW'(WIDTH);
                        rem_d   = '0;
                        quo_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        dbz_d   = 1'b0;
                    end
                end
            end
            StRun: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d     = StDone;
                    quotient_d  = res_quo;
                    remainder_d = res_rem;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);
    assign dbz_o       = dbz_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule
